core_dl1_resp: RTL and testbench

CORE_DL1_RESP -- requirements
Module: core_dl1_resp

---
 rtl/core_pkg.sv | 25 ++
 rtl/core_dl1_resp_mem.sv | 18 +
 rtl/core_dl1_resp.sv | 78 +++++++
 tb/tb_core_dl1_resp.sv | 114 +++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared DL1 definitions, access size/op codes and response FSM states
package core_pkg;
  localparam int DL1_WORD_W = 32;
  localparam int DL1_LANES = DL1_WORD_W / 8;
  typedef enum logic [2:0] {
    SZ_BYTE = 3'b001,
    SZ_HALF = 3'b010,
    SZ_WORD = 3'b100
  } size_e;
  typedef enum logic {
    COP_RD = 1'b0,
    COP_WR = 1'b1
  } cop_e;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;
  // Lane enables for a size/offset pair; misaligned halves and words are force-aligned.
  function automatic logic [DL1_LANES-1:0] dl1_be(input logic [2:0] size, input logic [1:0] ofs);
    return size == SZ_BYTE ? 4'b0001 << ofs :
           size == SZ_HALF ? (ofs[1] ? 4'b1100 : 4'b0011) :
           size == SZ_WORD ? 4'b1111 : 4'b0000;
  endfunction
endpackage

// File: rtl/core_dl1_resp_mem.sv
// core_dl1_resp_mem: single-port word array with per-byte write enables and combinational read
module core_dl1_resp_mem #(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] i_idx,
  input  logic [3:0]    i_be,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [DEPTH];
  // Byte-lane writes; contents are deliberately never reset.
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (i_be[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
  assign o_rdata = r_mem[i_idx];
endmodule

// File: rtl/core_dl1_resp.sv
// core_dl1_resp: fixed-latency DL1 request/response unit; define DL1_RESP_ALIGN_CHECK_EN to flag misaligned accesses
module core_dl1_resp
  import core_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_val,
  input  logic        req_cop,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = LATENCY == 0 ? 4'd0 : 4'(LATENCY - 1);
  state_e r_state, w_next;
  logic [3:0] r_cnt;
  logic r_cop;
  logic [2:0] r_size;
  logic [AW+1:0] r_addr;
  logic [31:0] r_wdata, w_word, w_sh, w_wdata, w_lane;
  logic w_size_ok, w_mis, w_err, w_we;
  logic [3:0] w_be;
  logic w_unused;
  assign w_unused = &{1'b0, req_addr[31:AW+2]};
  // State and wait counter; request fields are latched only on acceptance in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && req_val) begin
        r_cnt <= CNT_INIT;
        r_cop <= req_cop;
        r_size <= req_size;
        r_addr <= req_addr[AW+1:0];
        r_wdata <= req_wdata;
      end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end
  // Next state: IDLE accepts, WAIT counts down to zero, RESP lasts a single cycle.
  always_comb begin
    w_next = r_state;
    w_next = r_state == ST_IDLE ? (req_val ? (LATENCY == 0 ? ST_RESP : ST_WAIT) : ST_IDLE) :
             r_state == ST_WAIT ? (r_cnt == 4'd0 ? ST_RESP : ST_WAIT) : ST_IDLE;
  end
  assign w_size_ok = r_size == SZ_BYTE || r_size == SZ_HALF || r_size == SZ_WORD;
`ifdef DL1_RESP_ALIGN_CHECK_EN
  assign w_mis = (r_size == SZ_HALF && r_addr[0]) || (r_size == SZ_WORD && r_addr[1:0] != 2'b00);
`else
  assign w_mis = 1'b0;
`endif
  assign w_err = !w_size_ok || w_mis;
  assign ack = r_state == ST_RESP && !rst;
  assign err = ack && w_err;
  assign w_we = ack && r_cop == COP_WR && !w_err;
  assign w_be = w_we ? dl1_be(r_size, r_addr[1:0]) : 4'b0000;
  assign w_wdata = r_size == SZ_BYTE ? {4{r_wdata[7:0]}} : r_size == SZ_HALF ? {2{r_wdata[15:0]}} : r_wdata;
  assign w_sh = w_word >> {r_addr[1:0], 3'b000};
  assign w_lane = r_size == SZ_BYTE ? {24'b0, w_sh[7:0]} :
                  r_size == SZ_HALF ? (r_addr[1] ? {16'b0, w_word[31:16]} : {16'b0, w_word[15:0]}) : w_word;
  assign rdata = ack && !w_err ? w_lane : 32'b0;
  core_dl1_resp_mem #(.DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .i_idx(r_addr[AW+1:2]),
    .i_be(w_be),
    .i_wdata(w_wdata),
    .o_rdata(w_word)
  );
endmodule

// File: tb/tb_core_dl1_resp.sv
// tb_core_dl1_resp: scoreboard bench for core_dl1_resp (LATENCY=2 main instance, LATENCY=0 back-to-back instance)
module tb_core_dl1_resp;
  import core_pkg::*;
  logic clk = 1'b0;
  logic rst, req_val, req_val0, req_cop;
  logic [2:0] req_size;
  logic [31:0] req_addr, req_wdata;
  logic ack, err, ack0, err0;
  logic [31:0] rdata, rdata0;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [31:0] rdata;
    logic err;
    logic chk_rd;
  } exp_t;
  exp_t exp_q[$];
  always #5 clk = ~clk;
  core_dl1_resp #(.DEPTH(256), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_val(req_val), .req_cop(req_cop), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .err(err)
  );
  core_dl1_resp #(.DEPTH(256), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req_val(req_val0), .req_cop(req_cop), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack0), .rdata(rdata0), .err(err0)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask
  task automatic do_req(input string tag, input logic cop, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err, input logic chk_rd);
    exp_t e;
    int n;
    e = '{exp_rd, exp_err, chk_rd};
    exp_q.push_back(e);
    @(negedge clk);
    req_val = 1'b1; req_cop = cop; req_size = size; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_val = 1'b0; req_cop = ~cop; req_size = 3'b001; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 20);
    check({tag, "_ack"}, 32'(ack), 32'd1);
    e = exp_q.pop_front();
    if (ack) begin
      check({tag, "_lat"}, 32'(n), 32'd3);
      check({tag, "_err"}, 32'(err), 32'(e.err));
      if (e.chk_rd) check({tag, "_rdata"}, rdata, e.rdata);
      @(negedge clk);
      check({tag, "_pulse"}, 32'(ack), 32'd0);
    end
  endtask
  initial begin
    rst = 1'b1; req_val = 1'b0; req_val0 = 1'b0; req_cop = 1'b0;
    req_size = 3'b001; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle", {ack0, err, ack, rdata[28:0]}, 32'd0);
    end
    do_req("wr_w10", COP_WR, SZ_WORD, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
    do_req("rd_w10", COP_RD, SZ_WORD, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    do_req("wr_b13", COP_WR, SZ_BYTE, 32'h13, 32'h0000_005A, 32'h0, 1'b0, 1'b0);
    do_req("rd_b13", COP_RD, SZ_BYTE, 32'h13, 32'h0, 32'h0000_005A, 1'b0, 1'b1);
    do_req("rd_w10b", COP_RD, SZ_WORD, 32'h10, 32'h0, 32'h5AAD_BEEF, 1'b0, 1'b1);
    do_req("rd_h12", COP_RD, SZ_HALF, 32'h12, 32'h0, 32'h0000_5AAD, 1'b0, 1'b1);
`ifdef DL1_RESP_ALIGN_CHECK_EN
    do_req("rd_h11", COP_RD, SZ_HALF, 32'h11, 32'h0, 32'h0, 1'b1, 1'b1);
`else
    do_req("rd_h11", COP_RD, SZ_HALF, 32'h11, 32'h0, 32'h0000_BEEF, 1'b0, 1'b1);
`endif
    do_req("wr_bad", COP_WR, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1'b1);
    do_req("rd_wrap", COP_RD, SZ_WORD, 32'h410, 32'h0, 32'h5AAD_BEEF, 1'b0, 1'b1);
    do_req("wr_h16", COP_WR, SZ_HALF, 32'h16, 32'h0000_1234, 32'h0, 1'b0, 1'b0);
    do_req("rd_h16", COP_RD, SZ_HALF, 32'h16, 32'h0, 32'h0000_1234, 1'b0, 1'b1);
    do_req("rd_b17", COP_RD, SZ_BYTE, 32'h17, 32'h0, 32'h0000_0012, 1'b0, 1'b1);
    @(negedge clk);
    req_val = 1'b1; req_cop = COP_WR; req_size = SZ_WORD; req_addr = 32'h10; req_wdata = 32'h1111_1111;
    @(posedge clk);
    #1 req_val = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("abort_rst_ack", 32'(ack), 32'd0);
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort_ack", 32'(ack), 32'd0);
    end
    do_req("rd_abort", COP_RD, SZ_WORD, 32'h10, 32'h0, 32'h5AAD_BEEF, 1'b0, 1'b1);
    @(negedge clk);
    req_cop = COP_WR; req_size = SZ_WORD; req_addr = 32'h20; req_wdata = 32'h0BAD_F00D; req_val0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b2b_ack0", 32'(ack0), 32'(i % 2 == 0));
    end
    req_val0 = 1'b0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
